// File: rtl/mem_mapper_nx_pkg.sv
// Shared constants and helpers for the parametrised CPU memory mapper.
package mem_mapper_pkg;

  localparam int SEL_CODE_W = 4;

  // Default top-level map: ROM, LED/UART, DDR3 and one spare region.
  localparam logic [SEL_CODE_W-1:0] SEL_ROM      = 4'h1;
  localparam logic [SEL_CODE_W-1:0] SEL_LED_UART = 4'h2;
  localparam logic [SEL_CODE_W-1:0] SEL_DDR3     = 4'h3;
  localparam logic [SEL_CODE_W-1:0] SEL_SPARE    = 4'h4;
  localparam logic [4*SEL_CODE_W-1:0] DEFAULT_SLAVE_SEL =
    {SEL_SPARE, SEL_DDR3, SEL_LED_UART, SEL_ROM};

  // Slave indices run 0..NUM_SLAVES-1; the dummy responder sits one past the last slave.
  function automatic int idx_width(input int num_slaves);
    return $clog2(num_slaves + 1);
  endfunction

  function automatic int dummy_index(input int num_slaves);
    return num_slaves;
  endfunction

endpackage

// File: rtl/mem_mapper_nx_if.sv
// CPU-side request/return bus of the memory mapper.
interface mem_mapper_nx_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [BE_W-1:0]   byte_enable;
  logic              write_req;
  logic              read_req;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;

  modport master (
    input  ready, read_data, read_data_valid,
    output addr, write_data, byte_enable, write_req, read_req
  );

  modport slave (
    output ready, read_data, read_data_valid,
    input  addr, write_data, byte_enable, write_req, read_req
  );

endinterface

// File: rtl/mem_mapper_nx_rd_tracker.sv
// Outstanding-read tracker: pending count, owning slave, dummy responder, stall and return mux.
// Optional MEM_MAPPER_ERR_STATUS_EN adds a flag for strobes from non-owner slaves.
module mem_mapper_rd_tracker
  import mem_mapper_pkg::*;
#(
  parameter int NUM_SLAVES      = 4,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int IDX_W           = idx_width(NUM_SLAVES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_req,
  input  logic [IDX_W-1:0]             sel_idx,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_read_data,
  input  logic [NUM_SLAVES-1:0]        s_read_data_valid,
  output logic                         stall,
  output logic                         ready,
  output logic [DATA_W-1:0]            read_data,
  output logic                         read_data_valid
`ifdef MEM_MAPPER_ERR_STATUS_EN
  ,
  output logic                         foreign_strobe
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int N_EXT = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] DUMMY   = IDX_W'(dummy_index(NUM_SLAVES));

  logic [CNT_W-1:0]  pend_cnt;
  logic [IDX_W-1:0]  cur_sel;
  logic              dummy_v;
  logic              acc;
  logic              full;
  logic [N_EXT-1:0]  ready_ext;
  logic [N_EXT-1:0]  valid_ext;
  logic [DATA_W-1:0] data_ext [N_EXT];

  // Widen the slave vectors so every index value, including the dummy slot, is addressable.
  always_comb begin
    ready_ext = '0;
    valid_ext = '0;
    for (int i = 0; i < N_EXT; i++) data_ext[i] = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      ready_ext[i] = s_ready[i];
      valid_ext[i] = s_read_data_valid[i];
      data_ext[i]  = s_read_data[i*DATA_W +: DATA_W];
    end
    ready_ext[NUM_SLAVES] = 1'b1;
    valid_ext[NUM_SLAVES] = dummy_v;
  end

  // A return this cycle frees a slot, so a full tracker can still accept in the same cycle.
  always_comb begin
    read_data_valid = !reset && (pend_cnt != '0) && valid_ext[cur_sel];
    read_data       = read_data_valid ? data_ext[cur_sel] : '0;
    full            = (pend_cnt == MAX_CNT) && !read_data_valid;
    stall           = read_req && (full || ((pend_cnt != '0) && (sel_idx != cur_sel)));
    ready           = !stall && ready_ext[sel_idx];
    acc             = read_req && ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_cnt <= '0;
      cur_sel  <= '0;
      dummy_v  <= 1'b0;
    end else begin
      pend_cnt <= pend_cnt + CNT_W'(acc) - CNT_W'(read_data_valid);
      if (acc) cur_sel <= sel_idx;
      dummy_v  <= acc && (sel_idx == DUMMY);
    end
  end

`ifdef MEM_MAPPER_ERR_STATUS_EN
  always_comb begin
    foreign_strobe = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (s_read_data_valid[i] && (IDX_W'(i) != cur_sel)) foreign_strobe = 1'b1;
    if (reset || (pend_cnt == '0)) foreign_strobe = 1'b0;
  end
`endif

endmodule

// File: rtl/mem_mapper_nx.sv
// Parametrised CPU memory mapper: select-field decode, strobe fan-out, in-order read returns.
// Optional MEM_MAPPER_ERR_STATUS_EN adds sticky error capture (err_valid/err_addr/err_clear).
module mem_mapper_nx
  import mem_mapper_pkg::*;
#(
  parameter int NUM_SLAVES      = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int SEL_HI          = 31,
  parameter int SEL_LO          = 28,
  parameter logic [NUM_SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLAVE_SEL = DEFAULT_SLAVE_SEL,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  mem_mapper_nx_if.slave                 bus,
  input  logic [NUM_SLAVES-1:0]          s_ready,
  output logic [NUM_SLAVES*ADDR_W-1:0]   s_addr,
  output logic [NUM_SLAVES*DATA_W-1:0]   s_write_data,
  output logic [NUM_SLAVES*DATA_W/8-1:0] s_byte_enable,
  output logic [NUM_SLAVES-1:0]          s_write_req,
  output logic [NUM_SLAVES-1:0]          s_read_req,
  input  logic [NUM_SLAVES*DATA_W-1:0]   s_read_data,
  input  logic [NUM_SLAVES-1:0]          s_read_data_valid
`ifdef MEM_MAPPER_ERR_STATUS_EN
  ,
  input  logic                           err_clear,
  output logic                           err_valid,
  output logic [ADDR_W-1:0]              err_addr
`endif
);

  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam logic [IDX_W-1:0] DUMMY = IDX_W'(dummy_index(NUM_SLAVES));

  logic [IDX_W-1:0]  sel_idx;
  logic              rd_stall;
  logic              trk_ready;
  logic              trk_valid;
  logic [DATA_W-1:0] trk_data;
`ifdef MEM_MAPPER_ERR_STATUS_EN
  logic              foreign_strobe;
  logic              unmapped_req;
`endif

  // Scan downwards so the lowest matching index wins on duplicated codes.
  always_comb begin
    sel_idx = DUMMY;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (bus.addr[SEL_HI:SEL_LO] == SLAVE_SEL[i*SEL_W +: SEL_W]) sel_idx = IDX_W'(i);
  end

  mem_mapper_rd_tracker #(
    .NUM_SLAVES      (NUM_SLAVES),
    .DATA_W          (DATA_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .IDX_W           (IDX_W)
  ) u_rd_tracker (
    .clk               (clk),
    .reset             (reset),
    .read_req          (bus.read_req),
    .sel_idx           (sel_idx),
    .s_ready           (s_ready),
    .s_read_data       (s_read_data),
    .s_read_data_valid (s_read_data_valid),
    .stall             (rd_stall),
    .ready             (trk_ready),
    .read_data         (trk_data),
    .read_data_valid   (trk_valid)
`ifdef MEM_MAPPER_ERR_STATUS_EN
    ,
    .foreign_strobe    (foreign_strobe)
`endif
  );

  assign bus.ready           = trk_ready;
  assign bus.read_data       = trk_data;
  assign bus.read_data_valid = trk_valid;

  assign s_addr        = {NUM_SLAVES{bus.addr}};
  assign s_write_data  = {NUM_SLAVES{bus.write_data}};
  assign s_byte_enable = {NUM_SLAVES{bus.byte_enable}};

  // Writes are posted and never wait on pending reads; unmapped ones simply raise no strobe.
  always_comb begin
    s_read_req  = '0;
    s_write_req = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_read_req[i]  = !reset && bus.read_req && !rd_stall && (sel_idx == IDX_W'(i));
      s_write_req[i] = !reset && bus.write_req && (sel_idx == IDX_W'(i));
    end
  end

`ifdef MEM_MAPPER_ERR_STATUS_EN
  assign unmapped_req = (bus.read_req || bus.write_req) && (sel_idx == DUMMY);

  // First error sticks until cleared; a new error in the clearing cycle re-captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if ((unmapped_req || foreign_strobe) && (!err_valid || err_clear)) begin
      err_valid <= 1'b1;
      err_addr  <= unmapped_req ? bus.addr : '0;
    end else if (err_clear) begin
      err_valid <= 1'b0;
    end
  end
`endif

endmodule
